// File: rtl/nios_hex_pkg.sv
// Shared constants and types for the Nios seven-segment scan driver.
package nios_hex_pkg;

    // Largest digit count the address map and STATUS index field can hold
    localparam int unsigned MAX_DIGITS = 6;

    // Register map
    localparam logic [2:0] ADDR_CTRL = 3'd6;
    localparam logic [2:0] ADDR_STAT = 3'd7;

    // CTRL field positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MASK_LSB = 8;
    localparam int unsigned CTRL_MASK_MSB = 13;

    // Scan sequencer states; encoding is visible through STATUS[6:5]
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/nios_hex_scan_timer.sv
// Load / count-down timer; done is high while the count sits at zero.
// A load of N-1 therefore holds the caller in its state for exactly N cycles.
module nios_hex_scan_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Count register: clear wins over load, load wins over decrement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/nios_hex_scan_driver.sv
// Avalon-MM seven-segment scan driver: per-digit pattern registers, blanked
// time-multiplexing onto a shared segment bus, per-digit blink.
module nios_hex_scan_driver
    import nios_hex_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SEG_W        = 7,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_DIV    = 25,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          DIG_ACT_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int unsigned MAX_TIME = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TMR_W    = $clog2(MAX_TIME + 1);
    localparam int unsigned FRM_W    = $clog2(BLINK_DIV + 1);

    localparam logic [TMR_W-1:0]      DWELL_LOAD = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [TMR_W-1:0]      BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
    localparam logic [FRM_W-1:0]      FRAME_LAST = FRM_W'(BLINK_DIV - 1);
    localparam logic [2:0]            IDX_LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF    = {SEG_W{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACT_LOW}};

    // Register file
    logic [SEG_W-1:0] dig_q [NUM_DIGITS];
    logic             ctrl_en_q;
    logic [5:0]       blink_mask_q;
    logic             wr_en;

    // Scan sequencer
    scan_state_t      state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             phase_q, phase_d;
    logic [SEG_W-1:0] sh_q, sh_d;

    // Shared dwell/blank timer
    logic             tmr_clear;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_done;

    // Output path (active-high until the output register)
    logic [SEG_W-1:0]      dig_sel;
    logic                  mask_sel;
    logic [SEG_W-1:0]      seg_pat;
    logic [NUM_DIGITS-1:0] dig_onehot;
    logic [SEG_W-1:0]      seg_q;
    logic [NUM_DIGITS-1:0] dig_en_q;

    // Only the low pattern bits and the CTRL fields of writedata are stored
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // Avalon writes: digit patterns and CTRL; other addresses are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                dig_q[i] <= '0;
            end
            ctrl_en_q    <= 1'b0;
            blink_mask_q <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (address == i[2:0]) begin
                    dig_q[i] <= writedata[SEG_W-1:0];
                end
            end
            if (address == ADDR_CTRL) begin
                ctrl_en_q    <= writedata[CTRL_EN_BIT];
                blink_mask_q <= writedata[CTRL_MASK_MSB:CTRL_MASK_LSB];
            end
        end
    end

    // Combinational read mux, zero-filled for unmapped addresses and bits
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN_BIT]                 = ctrl_en_q;
                readdata[CTRL_MASK_MSB:CTRL_MASK_LSB] = blink_mask_q;
            end
            ADDR_STAT: begin
                readdata[2:0] = idx_q;
                readdata[4]   = phase_q;
                readdata[6:5] = state_q;
            end
            default: begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (address == i[2:0]) begin
                        readdata[SEG_W-1:0] = dig_q[i];
                    end
                end
            end
        endcase
    end

    // Pattern and blink-mask bit of the digit currently addressed by idx
    always_comb begin
        dig_sel  = '0;
        mask_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == i[2:0]) begin
                dig_sel = dig_q[i];
            end
        end
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (idx_q == i[2:0]) begin
                mask_sel = blink_mask_q[i];
            end
        end
    end

    nios_hex_scan_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Sequencer next state: blank/on alternation, digit advance, frame and blink phase
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        phase_d      = phase_q;
        sh_d         = sh_q;
        tmr_clear    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = BLANK_LOAD;

        if (!ctrl_en_q) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            frame_d   = '0;
            phase_d   = 1'b0;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_BLANK;
                    tmr_load     = 1'b1;
                    tmr_load_val = BLANK_LOAD;
                end
                ST_BLANK: begin
                    if (tmr_done) begin
                        state_d      = ST_ON;
                        tmr_load     = 1'b1;
                        tmr_load_val = DWELL_LOAD;
                        sh_d         = dig_sel;
                    end
                end
                ST_ON: begin
                    if (tmr_done) begin
                        state_d      = ST_BLANK;
                        tmr_load     = 1'b1;
                        tmr_load_val = BLANK_LOAD;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            if (frame_q == FRAME_LAST) begin
                                frame_d = '0;
                                phase_d = ~phase_q;
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            sh_q    <= sh_d;
        end
    end

    // Output values are derived from the next state so the pins change on the
    // same edge as the sequencer; idx and mask only move when leaving ON.
    always_comb begin
        seg_pat    = '0;
        dig_onehot = '0;
        if (state_d == ST_ON) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == i[2:0]) begin
                    dig_onehot[i] = 1'b1;
                end
            end
            seg_pat = (mask_sel && phase_d) ? '0 : sh_d;
        end
    end

    // Output registers; pin polarity is applied only here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q    <= SEG_OFF;
            dig_en_q <= DIG_OFF;
        end else begin
            seg_q    <= SEG_ACT_LOW ? ~seg_pat : seg_pat;
            dig_en_q <= DIG_ACT_LOW ? ~dig_onehot : dig_onehot;
        end
    end

    assign seg_out = seg_q;
    assign dig_en  = dig_en_q;

endmodule
